// File: rtl/conv_pkg.sv
// Shared constants for the convolution datapath and its window front-end.
// Also provides the counter-width helper used by the position counters and line-buffer address.
package conv_pkg;

  localparam int DEF_IMAGE_WIDTH = 8;
  localparam int DEF_MATRIX_SIZE = 3;

  // Counters and addresses need at least one bit, even for a range of 1 or 2.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv_window_gen_if.sv
// Pixel-in / window-out handshake bundle for conv_window_gen.
// The master side feeds pixels and consumes windows.
interface conv_window_gen_if
  import conv_pkg::*;
#(
  parameter int IMAGE_WIDTH = DEF_IMAGE_WIDTH,
  parameter int MATRIX_SIZE = DEF_MATRIX_SIZE
);

  logic                                         frame_clr;
  logic                                         in_valid;
  logic                                         in_ready;
  logic [IMAGE_WIDTH-1:0]                       in_pixel;
  logic                                         out_valid;
  logic                                         out_ready;
  logic [IMAGE_WIDTH*MATRIX_SIZE*MATRIX_SIZE-1:0] out_matrix;
  logic                                         out_last;

  modport master (
    output frame_clr, in_valid, in_pixel, out_ready,
    input  in_ready, out_valid, out_matrix, out_last
  );

  modport slave (
    input  frame_clr, in_valid, in_pixel, out_ready,
    output in_ready, out_valid, out_matrix, out_last
  );

endinterface

// File: rtl/conv_window_gen_line_buffer.sv
// One image line of storage: combinational read and synchronous write at the same address,
// so a read in the write cycle returns the previous line's pixel. The RAM is not reset.
module line_buffer
  import conv_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int WIDTH = DEF_IMAGE_WIDTH,
  parameter int AW    = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  assign rd_data = mem[addr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[addr] <= wr_data;
  end

endmodule

// File: rtl/conv_window_gen.sv
// Streaming MATRIX_SIZE x MATRIX_SIZE window generator over a raster pixel stream.
// Emits only fully-interior windows, flattened in conv_mat.in_matrix packing.
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int IMAGE_WIDTH = DEF_IMAGE_WIDTH,
  parameter int MATRIX_SIZE = DEF_MATRIX_SIZE,
  parameter int IMG_COLS    = 32,
  parameter int IMG_ROWS    = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  conv_window_gen_if.slave   bus
);

  localparam int CW  = cnt_width(IMG_COLS);
  localparam int RW  = cnt_width(IMG_ROWS);
  localparam int NLB = MATRIX_SIZE - 1;
  localparam int MW  = IMAGE_WIDTH * MATRIX_SIZE * MATRIX_SIZE;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_ROWS - 1);
  localparam logic [CW-1:0] COL_MIN  = CW'(MATRIX_SIZE - 1);
  localparam logic [RW-1:0] ROW_MIN  = RW'(MATRIX_SIZE - 1);

  logic [CW-1:0]          col_cnt;
  logic [RW-1:0]          row_cnt;
  logic                   out_valid_q;
  logic                   out_last_q;
  logic                   accept;
  logic                   col_wrap;
  logic                   row_wrap;
  logic                   win_done;
  logic [IMAGE_WIDTH-1:0] lb_rd   [NLB];
  logic [IMAGE_WIDTH-1:0] new_col [MATRIX_SIZE];
  logic [IMAGE_WIDTH-1:0] win     [MATRIX_SIZE][MATRIX_SIZE];
  logic [MW-1:0]          mat_flat;

  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready && !bus.frame_clr;
  assign col_wrap     = (col_cnt == COL_LAST);
  assign row_wrap     = (row_cnt == ROW_LAST);
  assign win_done     = (row_cnt >= ROW_MIN) && (col_cnt >= COL_MIN);

  // Line buffers form a vertical delay chain: lb 0 holds the previous line, lb 1 the one before.
  for (genvar k = 0; k < NLB; k++) begin : g_lb
    if (k == 0) begin : g_head
      line_buffer #(.DEPTH(IMG_COLS), .WIDTH(IMAGE_WIDTH)) u_lb (
        .clk     (clk),
        .wr_en   (accept),
        .addr    (col_cnt),
        .wr_data (bus.in_pixel),
        .rd_data (lb_rd[k])
      );
    end else begin : g_tail
      line_buffer #(.DEPTH(IMG_COLS), .WIDTH(IMAGE_WIDTH)) u_lb (
        .clk     (clk),
        .wr_en   (accept),
        .addr    (col_cnt),
        .wr_data (lb_rd[k-1]),
        .rd_data (lb_rd[k])
      );
    end
  end

  // Top row of the new column comes from the oldest line buffer, bottom row is the live pixel.
  always_comb begin
    for (int r = 0; r < MATRIX_SIZE; r++) new_col[r] = '0;
    for (int r = 0; r < NLB; r++) new_col[r] = lb_rd[NLB-1-r];
    new_col[MATRIX_SIZE-1] = bus.in_pixel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < MATRIX_SIZE; r++)
        for (int c = 0; c < MATRIX_SIZE; c++)
          win[r][c] <= '0;
    end else if (accept) begin
      for (int r = 0; r < MATRIX_SIZE; r++) begin
        for (int c = 0; c < MATRIX_SIZE - 1; c++) win[r][c] <= win[r][c+1];
        win[r][MATRIX_SIZE-1] <= new_col[r];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt     <= '0;
      row_cnt     <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else if (bus.frame_clr) begin
      col_cnt     <= '0;
      row_cnt     <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      if (accept) begin
        if (col_wrap) begin
          col_cnt <= '0;
          row_cnt <= row_wrap ? '0 : row_cnt + 1'b1;
        end else begin
          col_cnt <= col_cnt + 1'b1;
        end
      end
      // A completing accept reloads the window in the same edge that consumes the old one.
      if (accept && win_done) begin
        out_valid_q <= 1'b1;
        out_last_q  <= row_wrap && col_wrap;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
    end
  end

  always_comb begin
    mat_flat = '0;
    for (int r = 0; r < MATRIX_SIZE; r++)
      for (int c = 0; c < MATRIX_SIZE; c++)
        mat_flat[(r*MATRIX_SIZE+c)*IMAGE_WIDTH +: IMAGE_WIDTH] = win[r][c];
  end

  assign bus.out_matrix = mat_flat;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_last   = out_last_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed and randomized bench for conv_window_gen on a 5x4 frame.
// Expected windows are cut straight out of a stored copy of the current frame.
module tb_conv_window_gen;

  localparam int IW   = 8;
  localparam int M    = 3;
  localparam int COLS = 5;
  localparam int ROWS = 4;
  localparam int MW   = IW * M * M;

  typedef struct packed {
    logic [MW-1:0] m;
    logic          l;
  } win_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  win_t          pend  [$];
  logic [MW-1:0] obs_m [$];
  logic          obs_l [$];
  logic [IW-1:0] img   [ROWS][COLS];
  int            r_pos = 0;
  int            c_pos = 0;

  always #5 clk = ~clk;

  conv_window_gen_if #(.IMAGE_WIDTH(IW), .MATRIX_SIZE(M)) bus ();

  conv_window_gen #(
    .IMAGE_WIDTH (IW),
    .MATRIX_SIZE (M),
    .IMG_COLS    (COLS),
    .IMG_ROWS    (ROWS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [IW-1:0] elem(input logic [MW-1:0] w, input int k);
    return w[k*IW +: IW];
  endfunction

  function automatic logic [MW-1:0] frame_win(input int r, input int c);
    logic [MW-1:0] w = '0;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++)
        w[(i*M+j)*IW +: IW] = img[r-M+1+i][c-M+1+j];
    return w;
  endfunction

  function automatic logic [MW-1:0] pat_win(input int r, input int c, input int base);
    logic [MW-1:0] w = '0;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++)
        w[(i*M+j)*IW +: IW] = 8'(base + (r-M+1+i)*16 + (c-M+1+j));
    return w;
  endfunction

  // One clock: drive inputs after negedge, check outputs, then advance the model for the edge.
  task automatic cycle(input logic v, input logic [IW-1:0] px, input logic ordy, input logic fclr);
    logic acc, rdy;
    bus.in_valid  = v;
    bus.in_pixel  = px;
    bus.out_ready = ordy;
    bus.frame_clr = fclr;
    #1;
    rdy = (pend.size() == 0) || ordy;
    chk("out_valid", MW'(bus.out_valid), MW'(pend.size() > 0));
    if (pend.size() > 0) begin
      chk("out_matrix", bus.out_matrix, pend[0].m);
      chk("out_last", MW'(bus.out_last), MW'(pend[0].l));
    end
    chk("in_ready", MW'(bus.in_ready), MW'(rdy));
    acc = v && rdy && !fclr;
    if (pend.size() > 0 && ordy) begin
      obs_m.push_back(bus.out_matrix);
      obs_l.push_back(bus.out_last);
      void'(pend.pop_front());
    end
    if (fclr) begin
      pend.delete();
      r_pos = 0;
      c_pos = 0;
    end else if (acc) begin
      img[r_pos][c_pos] = px;
      if (r_pos >= M-1 && c_pos >= M-1)
        pend.push_back('{m: frame_win(r_pos, c_pos), l: (r_pos == ROWS-1 && c_pos == COLS-1)});
      if (c_pos == COLS-1) begin
        c_pos = 0;
        r_pos = (r_pos == ROWS-1) ? 0 : r_pos + 1;
      end else begin
        c_pos++;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Offer n raster pixels; pv/pr are valid/ready percentages, stall forces ready low per window.
  task automatic send_pixels(input int base, input int n, input int pv, input int pr,
                             input int stall, input bit rndpix);
    int idx = 0;
    int guard = 0;
    int sc = 0;
    logic [IW-1:0] px;
    logic v, o, acc;
    px = rndpix ? IW'($urandom) : 8'(base + (idx/COLS)*16 + idx%COLS);
    while (idx < n && guard < 2000) begin
      v = ($urandom_range(99) < pv);
      o = ($urandom_range(99) < pr);
      if (pend.size() > 0 && sc < stall) begin
        o = 1'b0;
        sc++;
      end else if (pend.size() > 0 && o) begin
        sc = 0;
      end
      acc = v && ((pend.size() == 0) || o);
      cycle(v, px, o, 1'b0);
      if (acc) begin
        idx++;
        px = rndpix ? IW'($urandom) : 8'(base + (idx/COLS)*16 + idx%COLS);
      end
      guard++;
    end
    chk("send_progress", MW'(idx), MW'(n));
  endtask

  task automatic drain();
    repeat (3) cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic clear_logs();
    obs_m.delete();
    obs_l.delete();
  endtask

  task automatic check_frame(input int base, input int first);
    chk("win_count", MW'(obs_m.size() - first), MW'(6));
    for (int i = 0; i < 6 && first + i < obs_m.size(); i++) begin
      chk("pattern_win", obs_m[first+i], pat_win(M-1 + i/3, M-1 + i%3, base));
      chk("pattern_last", MW'(obs_l[first+i]), MW'(i == 5));
    end
  endtask

  task automatic check_first_last();
    if (obs_m.size() >= 6) begin
      chk("first_e0", MW'(elem(obs_m[0], 0)), MW'(8'h00));
      chk("first_e4", MW'(elem(obs_m[0], 4)), MW'(8'h11));
      chk("first_e8", MW'(elem(obs_m[0], 8)), MW'(8'h22));
      chk("last_e0", MW'(elem(obs_m[5], 0)), MW'(8'h12));
      chk("last_e8", MW'(elem(obs_m[5], 8)), MW'(8'h34));
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_pixel  = '0;
    bus.out_ready = 1'b0;
    bus.frame_clr = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", MW'(bus.out_valid), '0);
    chk("rst_out_last", MW'(bus.out_last), '0);
    chk("rst_out_matrix", bus.out_matrix, '0);
    chk("rst_in_ready", MW'(bus.in_ready), MW'(1));
    @(negedge clk);
    rst_n = 1'b1;

    // First frame, steady flow
    clear_logs();
    send_pixels(0, ROWS*COLS, 100, 100, 0, 1'b0);
    drain();
    check_frame(0, 0);
    check_first_last();

    // Three-cycle backpressure on every window
    clear_logs();
    send_pixels(0, ROWS*COLS, 100, 100, 3, 1'b0);
    drain();
    check_frame(0, 0);

    // Back-to-back frames
    clear_logs();
    send_pixels(0, ROWS*COLS, 100, 100, 0, 1'b0);
    send_pixels(8'h80, ROWS*COLS, 100, 100, 0, 1'b0);
    drain();
    chk("b2b_total", MW'(obs_m.size()), MW'(12));
    if (obs_m.size() >= 7) chk("b2b_e0", MW'(elem(obs_m[6], 0)), MW'(8'h80));
    check_frame(8'h80, 6);

    // frame_clr right after pixel 0x13, with a pixel offered in the same cycle
    clear_logs();
    send_pixels(0, 9, 100, 100, 0, 1'b0);
    cycle(1'b1, 8'h14, 1'b1, 1'b1);
    chk("fclr_out_valid", MW'(bus.out_valid), '0);
    send_pixels(0, ROWS*COLS, 100, 100, 0, 1'b0);
    drain();
    check_frame(0, 0);

    // Async reset while a window is held under backpressure
    clear_logs();
    send_pixels(0, 13, 100, 100, 0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    chk("pre_rst_valid", MW'(bus.out_valid), MW'(1));
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", MW'(bus.out_valid), '0);
    chk("arst_out_last", MW'(bus.out_last), '0);
    chk("arst_out_matrix", bus.out_matrix, '0);
    pend.delete();
    r_pos = 0;
    c_pos = 0;
    @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
    send_pixels(0, ROWS*COLS, 100, 100, 0, 1'b0);
    drain();
    check_frame(0, 0);
    check_first_last();

    // Random pixels with random valid and ready
    for (int f = 0; f < 4; f++) begin
      clear_logs();
      send_pixels(0, ROWS*COLS, 70, 60, 0, 1'b1);
      drain();
      chk("rnd_win_count", MW'(obs_m.size()), MW'(6));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
